mul_red_sched: RTL and testbench

//  Issue controller for the dual-lane 12-bit multiply/reduce datapath (K_redu pair or D_redu).

---
 rtl/mul_red_sched_if.sv | 32 +++
 rtl/mul_red_sched.sv | 133 +++++++++++++
 tb/tb_mul_red_sched.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/mul_red_sched_if.sv
// rtl/mul_red_sched_if.sv - request/result handshake bundle for mul_red_sched
//
// Purpose: groups the operation-request channel and the tagged-result channel
// between the NTT/INTT stage sequencer (master) and the issue controller (slave).
// Signals:
//   in_valid / in_ready   request handshake, accepted when both are high
//   in_mode               00 K_NTT, 01 K_INTT, 10 D_NTT, 11 D_INTT
//   in_tag / in_last      request tag and end-of-batch marker
//   out_valid             datapath result valid this cycle (no backpressure)
//   out_tag / out_last    tag and end-of-batch marker of that result
interface mul_red_sched_if #(
  parameter int TAG_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_mode;
  logic [TAG_W-1:0] in_tag;
  logic             in_last;
  logic             out_valid;
  logic [TAG_W-1:0] out_tag;
  logic             out_last;

  modport master (
    output in_valid, in_mode, in_tag, in_last,
    input  in_ready, out_valid, out_tag, out_last
  );

  modport slave (
    input  in_valid, in_mode, in_tag, in_last,
    output in_ready, out_valid, out_tag, out_last
  );
endinterface

// File: rtl/mul_red_sched.sv
// rtl/mul_red_sched.sv - issue controller for the dual-lane 12-bit multiply/reduce datapath
//
// Purpose: accepts tagged operation requests, drives the datapath selects for the
// requested mode, tracks in-flight ops in a valid/tag pipe and returns tagged
// results. A mode change drains the pipe, loads the new selects and inserts one
// settle cycle before the next accept.
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous reset, active low
//   bus           request/result channels (slave side)
//   op_fire       upstream presents A/w this cycle (= accept)
//   sel_a         datapath w-select (10 = delayed w)
//   sel_D_2_INTT  datapath A-select (1 = delayed A)
//   mul_Red_mode  0 K_redu, 1 D_redu
//   busy          FSM not idle or ops in flight
module mul_red_sched #(
  parameter int PIPE_LAT = 3,
  parameter int TAG_W    = 8
) (
  input  logic           clk,
  input  logic           rst,
  mul_red_sched_if.slave bus,
  output logic           op_fire,
  output logic [1:0]     sel_a,
  output logic           sel_D_2_INTT,
  output logic           mul_Red_mode,
  output logic           busy
);

  localparam int DEPTH = PIPE_LAT + 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, SWITCH, SETTLE} state_t;

  state_t           state;
  logic [1:0]       cur_mode;
  logic [1:0]       pend_mode;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic [DEPTH-1:0] pipe_valid;
  logic [DEPTH-1:0] pipe_last;
  logic [TAG_W-1:0] pipe_tag [DEPTH];
  logic             mode_hit;
  logic             accept;
  logic             retire;

  // Returns {sel_a, sel_D_2_INTT, mul_Red_mode}; the INTT modes use the delayed w.
  function automatic logic [3:0] decode(input logic [1:0] m);
    decode = {m[0], 1'b0, m[1] & m[0], m[1]};
  endfunction

  assign mode_hit     = (bus.in_mode == cur_mode);
  assign bus.in_ready = rst && ((state == IDLE) || (state == RUN)) && mode_hit;
  assign accept       = bus.in_valid && bus.in_ready;
  assign op_fire      = accept;

  // INTT modes carry one extra delay stage in the datapath, so they tap one stage later.
  assign bus.out_valid = cur_mode[0] ? pipe_valid[PIPE_LAT] : pipe_valid[PIPE_LAT-1];
  assign bus.out_last  = cur_mode[0] ? pipe_last[PIPE_LAT]  : pipe_last[PIPE_LAT-1];
  assign bus.out_tag   = cur_mode[0] ? pipe_tag[PIPE_LAT]   : pipe_tag[PIPE_LAT-1];

  assign retire     = bus.out_valid;
  assign count_next = count + CNT_W'(accept) - CNT_W'(retire);
  assign busy       = (state != IDLE) || (count != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe_valid <= '0;
      pipe_last  <= '0;
      for (int i = 0; i < DEPTH; i++) pipe_tag[i] <= '0;
    end else begin
      pipe_valid[0] <= accept;
      pipe_last[0]  <= accept && bus.in_last;
      pipe_tag[0]   <= accept ? bus.in_tag : '0;
      for (int i = 1; i < DEPTH; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_last[i]  <= pipe_last[i-1];
        pipe_tag[i]   <= pipe_tag[i-1];
      end
      // An entry already retired at the short tap must never show up at the long tap.
      if (!cur_mode[0]) begin
        pipe_valid[PIPE_LAT] <= 1'b0;
        pipe_last[PIPE_LAT]  <= 1'b0;
        pipe_tag[PIPE_LAT]   <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cur_mode     <= 2'b00;
      pend_mode    <= 2'b00;
      count        <= '0;
      sel_a        <= 2'b00;
      sel_D_2_INTT <= 1'b0;
      mul_Red_mode <= 1'b0;
    end else begin
      count <= count_next;
      case (state)
        IDLE: begin
          if (accept) begin
            state <= RUN;
          end else if (bus.in_valid && !mode_hit) begin
            // Nothing is in flight, so this cycle doubles as the switch cycle.
            cur_mode <= bus.in_mode;
            {sel_a, sel_D_2_INTT, mul_Red_mode} <= decode(bus.in_mode);
            state <= SETTLE;
          end
        end
        RUN: begin
          if (bus.in_valid && !mode_hit) begin
            pend_mode <= bus.in_mode;
            state     <= DRAIN;
          end else if (count_next == '0) begin
            state <= IDLE;
          end
        end
        DRAIN: begin
          if (count_next == '0) state <= SWITCH;
        end
        SWITCH: begin
          cur_mode <= pend_mode;
          {sel_a, sel_D_2_INTT, mul_Red_mode} <= decode(pend_mode);
          state <= SETTLE;
        end
        SETTLE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_red_sched.sv
// tb/tb_mul_red_sched.sv - scoreboard testbench for mul_red_sched
module tb_mul_red_sched;

  typedef struct {
    logic [7:0] tag;
    logic       last;
    int         due;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       op_fire;
  logic [1:0] sel_a;
  logic       sel_d;
  logic       mrm;
  logic       busy;

  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  logic mon_en = 1'b0;
  exp_t sb[$];

  // Reference model state
  logic [1:0] m_mode;
  int         m_ok_at;
  logic [1:0] m_sel_mode;
  logic [1:0] m_sel_target;
  int         m_sel_at;
  int         m_busy_lo;
  int         m_busy_hi;
  int         m_last_due;
  int         m_inflight[$];
  logic       last_acc;

  mul_red_sched_if #(.TAG_W(8)) bus ();

  mul_red_sched #(.PIPE_LAT(3), .TAG_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .op_fire      (op_fire),
    .sel_a        (sel_a),
    .sel_D_2_INTT (sel_d),
    .mul_Red_mode (mrm),
    .busy         (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int lat(input logic [1:0] m);
    return m[0] ? 4 : 3;
  endfunction

  function automatic logic [3:0] exp_sel(input logic [1:0] m);
    case (m)
      2'b00:   return 4'b0000;
      2'b01:   return 4'b1000;
      2'b10:   return 4'b0001;
      default: return 4'b1011;
    endcase
  endfunction

  task automatic model_reset();
    m_mode       = 2'b00;
    m_ok_at      = 0;
    m_sel_mode   = 2'b00;
    m_sel_target = 2'b00;
    m_sel_at     = 0;
    m_busy_lo    = 1;
    m_busy_hi    = 0;
    m_last_due   = -100;
    m_inflight.delete();
    sb.delete();
  endtask

  // Drive one cycle of request inputs, then check the cycle against the model.
  task automatic step(input logic v, input logic [1:0] md, input logic [7:0] tg, input logic ls);
    int   c;
    int   s;
    logic er;
    logic eb;
    @(posedge clk);
    #1;
    bus.in_valid = v;
    bus.in_mode  = md;
    bus.in_tag   = tg;
    bus.in_last  = ls;
    @(negedge clk);
    c = cyc;
    while (m_inflight.size() > 0 && m_inflight[0] < c) void'(m_inflight.pop_front());
    if (c >= m_sel_at) m_sel_mode = m_sel_target;
    er = (c >= m_ok_at) && (md == m_mode);
    eb = (m_inflight.size() > 0) || (c >= m_busy_lo && c <= m_busy_hi);
    chk("in_ready", bus.in_ready, er);
    chk("op_fire", op_fire, v && er);
    chk("busy", busy, eb);
    chk("selects", {sel_a, sel_d, mrm}, exp_sel(m_sel_mode));
    last_acc = v && er;
    if (v && er) begin
      sb.push_back('{tag: tg, last: ls, due: c + lat(md)});
      m_inflight.push_back(c + lat(md));
      m_last_due = c + lat(md);
    end else if (v && c >= m_ok_at && md != m_mode) begin
      // Idle: switch now. Busy: drain everything, then switch.
      if (m_inflight.size() == 0) s = c;
      else s = (c + 2 > m_last_due + 1) ? c + 2 : m_last_due + 1;
      m_mode       = md;
      m_ok_at      = s + 2;
      m_sel_target = md;
      m_sel_at     = s + 1;
      m_busy_lo    = c + 1;
      m_busy_hi    = s + 1;
    end
  endtask

  task automatic send(input logic [1:0] md, input logic [7:0] tg, input logic ls);
    int n;
    n = 0;
    do begin
      step(1'b1, md, tg, ls);
      n++;
    end while (!last_acc && n < 20);
    if (!last_acc) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, bus.in_mode, 8'h00, 1'b0);
  endtask

  // Monitor: compares every presented result against the scoreboard head.
  always @(negedge clk) begin : monitor
    exp_t e;
    logic ev;
    if (mon_en && rst) begin
      ev = (sb.size() > 0) && (sb[0].due == cyc);
      chk("out_valid", bus.out_valid, ev);
      if (ev) begin
        e = sb.pop_front();
        if (bus.out_valid) begin
          chk("out_tag", bus.out_tag, e.tag);
          chk("out_last", bus.out_last, e.last);
        end
      end
    end
  end

  initial begin
    logic [1:0] rmode;
    bus.in_valid = 1'b1;
    bus.in_mode  = 2'b00;
    bus.in_tag   = 8'h5a;
    bus.in_last  = 1'b1;
    model_reset();
    #3;
    chk("rst_in_ready", bus.in_ready, 1'b0);
    chk("rst_op_fire", op_fire, 1'b0);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_tag", bus.out_tag, 8'h00);
    chk("rst_out_last", bus.out_last, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_selects", {sel_a, sel_d, mrm}, 4'b0000);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    rst = 1'b1;
    mon_en = 1'b1;

    // Eight back-to-back K_NTT ops, last on tag 7
    for (int i = 0; i < 8; i++) send(2'b00, 8'(i), i == 7);
    idle(6);
    // Three K_NTT ops then a D_INTT request: drain, switch, settle
    for (int i = 0; i < 3; i++) send(2'b00, 8'(8'h10 + i), 1'b0);
    send(2'b11, 8'h20, 1'b1);
    idle(8);
    // Idle pipe, K_INTT request: immediate switch
    send(2'b01, 8'h30, 1'b0);
    // Same-mode requests with in_valid toggling while ops are in flight
    step(1'b1, 2'b01, 8'h31, 1'b0);
    step(1'b0, 2'b01, 8'h32, 1'b0);
    step(1'b1, 2'b01, 8'h33, 1'b0);
    step(1'b0, 2'b01, 8'h34, 1'b0);
    step(1'b1, 2'b01, 8'h35, 1'b1);
    idle(6);
    // Continuous D_INTT stream
    for (int i = 0; i < 20; i++) send(2'b11, 8'(8'h40 + i), i == 19);
    idle(8);
    // Reset with three ops in flight
    for (int i = 0; i < 3; i++) send(2'b11, 8'(8'h60 + i), 1'b0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", bus.out_valid, 1'b0);
    chk("midrst_selects", {sel_a, sel_d, mrm}, 4'b0000);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_in_ready", bus.in_ready, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    idle(12);

    // Randomized traffic with sticky modes and in_valid gaps
    rmode = 2'b00;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 11) == 0) rmode = 2'($urandom_range(0, 3));
      step($urandom_range(0, 9) < 7, rmode, 8'($urandom), $urandom_range(0, 7) == 0);
    end
    idle(10);
    chk("scoreboard_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
